// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared button codes, blank pattern and BCD helpers for clock fields
package clock_pkg;

    localparam logic [3:0] BTN_INC   = 4'b1011;
    localparam logic [3:0] BTN_DEC   = 4'b0111;
    localparam logic [3:0] BTN_IDLE  = 4'b1111;
    localparam logic [7:0] BLANK_PAT = 8'hBB;

    // Binary 0..99 to two-digit packed BCD.
    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    // True when both digits are decimal and the value is below the modulus.
    function automatic logic bcd_valid(input logic [7:0] v, input int modulus);
        int bin;
        bin = int'(v[7:4]) * 10 + int'(v[3:0]);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (bin < modulus);
    endfunction

    // Increment with wrap from modulus-1 back to 0; input assumed valid.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input int modulus);
        logic [7:0] r;
        if (v == to_bcd(modulus - 1))
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Decrement with wrap from 0 up to modulus-1; input assumed valid.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input int modulus);
        logic [7:0] r;
        if (v == 8'h00)
            r = to_bcd(modulus - 1);
        else if (v[3:0] == 4'd0)
            r = {v[7:4] - 4'd1, 4'd9};
        else
            r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// rtl/blink_timer.sv - blink divider producing a phase that toggles every BLINK_DIV cycles
// clk1    : clock
// rst     : synchronous active-high reset
// en      : run the divider; low clears it on the next edge
// restart : clear divider and phase so the next value is shown immediately
// phase   : 1 = blank half-period
module blink_timer #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic clk1,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic phase
);

    localparam int             CW   = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(BLINK_DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk1) begin
        if (rst || !en || restart) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
            phase   <= ~phase;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/bcd_field_counter.sv
// rtl/bcd_field_counter.sv - one BCD clock field with run/calibrate modes, preset and blink
// clk1      : clock
// rst       : synchronous active-high reset
// tick      : count enable from the lower field (run mode)
// sw1       : 0 = run, 1 = calibrate
// btn_out   : button code (inc / dec / idle)
// btn_pos   : field currently selected for calibration
// load      : preset strobe, load_val applied when legal
// load_val  : BCD preset value
// cnt       : registered BCD count
// disp      : cnt or blank pattern
// co        : registered carry pulse on run-mode wrap
module bcd_field_counter
    import clock_pkg::*;
#(
    parameter int MODULUS   = 60,
    parameter int FIELD_ID  = 2,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk1,
    input  logic       rst,
    input  logic       tick,
    input  logic       sw1,
    input  logic [3:0] btn_out,
    input  logic [1:0] btn_pos,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] cnt,
    output logic [7:0] disp,
    output logic       co
);

    localparam logic [7:0] MAX_BCD = to_bcd(MODULUS - 1);

    logic selected;
    logic btn_inc;
    logic btn_dec;
    logic accept;
    logic phase;

    assign selected = sw1 && (btn_pos == 2'(FIELD_ID));
    assign btn_inc  = (btn_out == BTN_INC);
    assign btn_dec  = (btn_out == BTN_DEC);
    // Load outranks the buttons, so a button press under load is not accepted
    // and must not restart the blink.
    assign accept   = !load && selected && (btn_inc || btn_dec);

    blink_timer #(
        .BLINK_DIV(BLINK_DIV)
    ) u_blink (
        .clk1   (clk1),
        .rst    (rst),
        .en     (selected),
        .restart(accept),
        .phase  (phase)
    );

    always_ff @(posedge clk1) begin
        if (rst) begin
            cnt <= 8'h00;
            co  <= 1'b0;
        end else begin
            co <= 1'b0;
            if (load) begin
                if (bcd_valid(load_val, MODULUS))
                    cnt <= load_val;
            end else if (!sw1) begin
                if (tick) begin
                    cnt <= bcd_inc(cnt, MODULUS);
                    co  <= (cnt == MAX_BCD);
                end
            end else if (selected) begin
                if (btn_inc)
                    cnt <= bcd_inc(cnt, MODULUS);
                else if (btn_dec)
                    cnt <= bcd_dec(cnt, MODULUS);
            end
        end
    end

    assign disp = phase ? BLANK_PAT : cnt;

endmodule

// File: tb/tb_bcd_field_counter.sv
// tb/tb_bcd_field_counter.sv - self-checking bench for bcd_field_counter against a value-level model
module tb_bcd_field_counter;

    localparam int MODS [2] = '{60, 24};
    localparam int FIDS [2] = '{2, 1};
    localparam int DIVS [2] = '{4, 3};

    logic       clk1 = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       sw1 = 1'b0;
    logic [3:0] btn_out = 4'b1111;
    logic [1:0] btn_pos = 2'd0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;

    logic [7:0] cnt_a, disp_a, cnt_b, disp_b;
    logic       co_a, co_b;

    int n_cmp = 0;
    int n_err = 0;

    int mv   [2] = '{0, 0};
    int mco  [2] = '{0, 0};
    int mrun [2] = '{0, 0};

    always #5 clk1 = ~clk1;

    bcd_field_counter #(.MODULUS(60), .FIELD_ID(2), .BLINK_DIV(4)) dut_a (
        .clk1(clk1), .rst(rst), .tick(tick), .sw1(sw1), .btn_out(btn_out),
        .btn_pos(btn_pos), .load(load), .load_val(load_val),
        .cnt(cnt_a), .disp(disp_a), .co(co_a)
    );

    bcd_field_counter #(.MODULUS(24), .FIELD_ID(1), .BLINK_DIV(3)) dut_b (
        .clk1(clk1), .rst(rst), .tick(tick), .sw1(sw1), .btn_out(btn_out),
        .btn_pos(btn_pos), .load(load), .load_val(load_val),
        .cnt(cnt_b), .disp(disp_b), .co(co_b)
    );

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_bcd(input int n);
        return 8'((n / 10) * 16 + (n % 10));
    endfunction

    function automatic int m_legal(input logic [7:0] v, input int m);
        int t, o;
        t = int'(v[7:4]);
        o = int'(v[3:0]);
        return (t < 10 && o < 10 && (t * 10 + o) < m) ? 1 : 0;
    endfunction

    // Applies the field rules to the inputs present at the edge just taken.
    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            int  m;
            bit  en, inc, dec;
            m   = MODS[i];
            en  = sw1 && (int'(btn_pos) == FIDS[i]);
            inc = (btn_out == 4'b1011);
            dec = (btn_out == 4'b0111);
            if (rst) begin
                mv[i] = 0; mco[i] = 0; mrun[i] = 0;
            end else begin
                mco[i] = 0;
                if (load) begin
                    if (m_legal(load_val, m) != 0)
                        mv[i] = int'(load_val[7:4]) * 10 + int'(load_val[3:0]);
                end else if (!sw1) begin
                    if (tick) begin
                        mco[i] = (mv[i] == m - 1) ? 1 : 0;
                        mv[i]  = (mv[i] + 1) % m;
                    end
                end else if (en) begin
                    if (inc)      mv[i] = (mv[i] + 1) % m;
                    else if (dec) mv[i] = (mv[i] + m - 1) % m;
                end
                if (!en || (!load && (inc || dec))) mrun[i] = 0;
                else                                mrun[i] = mrun[i] + 1;
            end
        end
    endtask

    function automatic logic [7:0] exp_disp(input int i);
        return (((mrun[i] / DIVS[i]) % 2) == 1) ? 8'hBB : m_bcd(mv[i]);
    endfunction

    task automatic step();
        @(posedge clk1);
        model_update();
        #1;
        check_val("cnt60",  cnt_a,        m_bcd(mv[0]));
        check_val("co60",   {7'd0, co_a}, 8'(mco[0]));
        check_val("disp60", disp_a,       exp_disp(0));
        check_val("cnt24",  cnt_b,        m_bcd(mv[1]));
        check_val("co24",   {7'd0, co_b}, 8'(mco[1]));
        check_val("disp24", disp_b,       exp_disp(1));
    endtask

    initial begin
        // reset state
        rst = 1'b1; step(); rst = 1'b0;
        check_val("rst_cnt",  cnt_a,  8'h00);
        check_val("rst_disp", disp_a, 8'h00);

        // run-mode wrap at 59
        load = 1'b1; load_val = 8'h58; step(); load = 1'b0;
        tick = 1'b1; step();
        check_val("wrap60_59", cnt_a, 8'h59);
        check_val("wrap60_co0", {7'd0, co_a}, 8'h00);
        step();
        check_val("wrap60_00", cnt_a, 8'h00);
        check_val("wrap60_co1", {7'd0, co_a}, 8'h01);
        tick = 1'b0; step();
        check_val("wrap60_co_end", {7'd0, co_a}, 8'h00);

        // modulus 24 wrap and digit carry
        load = 1'b1; load_val = 8'h23; step(); load = 1'b0;
        tick = 1'b1; step(); tick = 1'b0;
        check_val("wrap24_00", cnt_b, 8'h00);
        check_val("wrap24_co", {7'd0, co_b}, 8'h01);
        load = 1'b1; load_val = 8'h09; step(); load = 1'b0;
        tick = 1'b1; step(); tick = 1'b0;
        check_val("carry24_10", cnt_b, 8'h10);

        // calibration dec/inc wrap, no carry
        rst = 1'b1; step(); rst = 1'b0;
        sw1 = 1'b1; btn_pos = 2'd2; btn_out = 4'b0111; step();
        check_val("cal_dec_59", cnt_a, 8'h59);
        check_val("cal_dec_co", {7'd0, co_a}, 8'h00);
        btn_out = 4'b1011; step();
        check_val("cal_inc_00", cnt_a, 8'h00);
        check_val("cal_inc_co", {7'd0, co_a}, 8'h00);
        btn_out = 4'b1111;

        // blink: 37 visible, blank after 4 cycles, inc shows 38 at once
        load = 1'b1; load_val = 8'h37; step(); load = 1'b0;
        check_val("blink_show", disp_a, 8'h37);
        repeat (3) step();
        check_val("blink_blank", disp_a, 8'hBB);
        repeat (3) step();
        check_val("blink_blank2", disp_a, 8'hBB);
        btn_out = 4'b1011; step(); btn_out = 4'b1111;
        check_val("blink_inc", disp_a, 8'h38);
        repeat (4) step();

        // reset mid-blink at 31
        load = 1'b1; load_val = 8'h31; step(); load = 1'b0;
        step();
        check_val("midblink_blank", disp_a, 8'hBB);
        rst = 1'b1; step(); rst = 1'b0;
        check_val("midblink_rst_cnt", cnt_a, 8'h00);
        check_val("midblink_rst_disp", disp_a, 8'h00);
        check_val("midblink_rst_co", {7'd0, co_a}, 8'h00);

        // leaving the selection unblanks on the next edge
        repeat (4) step();
        check_val("leave_blank", disp_a, 8'hBB);
        btn_pos = 2'd3; step();
        check_val("leave_show", disp_a, 8'h00);

        // load legality and priority over tick
        sw1 = 1'b0;
        load = 1'b1; load_val = 8'h75; step();
        check_val("load_bad", cnt_a, 8'h00);
        load_val = 8'h42; tick = 1'b1; step();
        check_val("load_42", cnt_a, 8'h42);
        check_val("load_co", {7'd0, co_a}, 8'h00);
        load = 1'b0; tick = 1'b0;

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rst      = ($urandom_range(0, 99) == 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = ($urandom_range(0, 1) == 1) ? 8'($urandom) : m_bcd($urandom_range(0, 59));
            if ($urandom_range(0, 31) == 0) sw1 = ~sw1;
            if ($urandom_range(0, 15) == 0) btn_pos = 2'($urandom);
            case ($urandom_range(0, 5))
                0:       btn_out = 4'b1011;
                1:       btn_out = 4'b0111;
                2:       btn_out = 4'($urandom);
                default: btn_out = 4'b1111;
            endcase
            tick = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
